// File: rtl/reg_file_sb.sv
// Integer register file with hardwired-zero x0, optional write-to-read bypass,
// per-register busy scoreboard and a post-reset clear sequence that gates ready.
module reg_file_sb #(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int BYPASS              = 1,
  parameter int A0_ADDR             = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  ready,
  input  logic                                  WE3,
  input  logic        [REG_FILE_ADDR_WIDTH-1:0] AD3,
  input  logic        [DATA_WIDTH-1:0]          WD3,
  input  logic        [REG_FILE_ADDR_WIDTH-1:0] AD1,
  input  logic        [REG_FILE_ADDR_WIDTH-1:0] AD2,
  output logic signed [DATA_WIDTH-1:0]          RD1,
  output logic signed [DATA_WIDTH-1:0]          RD2,
  output logic                                  BUSY1,
  output logic                                  BUSY2,
  input  logic                                  ISSUE_EN,
  input  logic        [REG_FILE_ADDR_WIDTH-1:0] ISSUE_AD,
  output logic signed [DATA_WIDTH-1:0]          a0
);

  localparam int DEPTH = 2 ** REG_FILE_ADDR_WIDTH;
  localparam logic [REG_FILE_ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [REG_FILE_ADDR_WIDTH-1:0] A0_IDX   = REG_FILE_ADDR_WIDTH'(A0_ADDR);

  typedef enum logic {INIT, RUN} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [REG_FILE_ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]               busy;
  logic                           wr_en;
  logic                           hit1;
  logic                           hit2;

  assign ready = (state == RUN);
  assign wr_en = ready && WE3 && (AD3 != '0);
  assign hit1  = (BYPASS != 0) && WE3 && (AD3 == AD1);
  assign hit2  = (BYPASS != 0) && WE3 && (AD3 == AD2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && clr_cnt == LAST_IDX) state_next = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == INIT)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Storage has no reset; the INIT sweep defines every entry before ready rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)  mem[clr_cnt] <= '0;
      else if (wr_en)     mem[AD3]     <= WD3;
    end
  end

  // Issue is applied after writeback so a same-register collision stays busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      if (wr_en)                          busy[AD3]      <= 1'b0;
      if (ISSUE_EN && ISSUE_AD != '0)     busy[ISSUE_AD] <= 1'b1;
    end
  end

  always_comb begin
    RD1   = '0;
    BUSY1 = 1'b0;
    if (ready && AD1 != '0) begin
      if (hit1) begin
        RD1 = WD3;
      end else begin
        RD1   = mem[AD1];
        BUSY1 = busy[AD1];
      end
    end
  end

  always_comb begin
    RD2   = '0;
    BUSY2 = 1'b0;
    if (ready && AD2 != '0) begin
      if (hit2) begin
        RD2 = WD3;
      end else begin
        RD2   = mem[AD2];
        BUSY2 = busy[AD2];
      end
    end
  end

  assign a0 = ready ? mem[A0_IDX] : '0;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's integer register file, for the pipelined core.
- Adds a hardwired-zero register 0, optional write-to-read bypass and a per-register scoreboard (busy bits), so decode can detect RAW hazards.
- Also adds a post-reset clear sequence, so the array contents are defined without a reset on every storage bit.
- Sits between decode (reads, issue) and writeback (write); exports the a0 register for the top-level test output.

Parameters:
- REG_FILE_ADDR_WIDTH, 5: register address width; DEPTH = 2**REG_FILE_ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports and clears BUSY on the read port; 0 = the array value is returned.
- A0_ADDR, 10: index of the register driven onto a0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sequence has finished.
- WE3  in  1  writeback write enable.
- AD3  in  REG_FILE_ADDR_WIDTH  write address.
- WD3  in  DATA_WIDTH  write data.
- AD1  in  REG_FILE_ADDR_WIDTH  read address, port 1.
- AD2  in  REG_FILE_ADDR_WIDTH  read address, port 2.
- RD1  out  DATA_WIDTH (signed)  read data, port 1.
- RD2  out  DATA_WIDTH (signed)  read data, port 2.
- BUSY1  out  1  AD1 has a pending write.
- BUSY2  out  1  AD2 has a pending write.
- ISSUE_EN  in  1  decode issues an instruction that will write ISSUE_AD.
- ISSUE_AD  in  REG_FILE_ADDR_WIDTH  destination register of the issued instruction.
- a0  out  DATA_WIDTH (signed)  stored value of register A0_ADDR.

Behaviour:
- Reset (asynchronous, rst high):
  - state = INIT, clear counter = 0, all busy bits = 0, ready = 0.
  - RD1, RD2 and a0 read 0; BUSY1 and BUSY2 = 0.
  - Takes effect immediately, including in the middle of a clear sequence or a write.
- State INIT:
  - Each cycle writes 0 to array[counter] and increments the counter.
  - On the cycle that clears entry DEPTH-1, the next state is RUN and ready rises on that edge.
  - INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - WE3 and ISSUE_EN are ignored.
  - RD1, RD2, a0 = 0; BUSY1, BUSY2 = 0.
- State RUN: remains here until rst.
- Write:
  - On the rising edge with WE3 = 1 and AD3 != 0, array[AD3] <= WD3.
  - Writes to register 0 are dropped.
- Read (combinational):
  - RDx = 0 if ADx == 0.
  - Otherwise, if BYPASS = 1 and WE3 = 1 and AD3 == ADx, RDx = WD3.
  - Otherwise RDx = array[ADx].
- a0 = array[A0_ADDR] (stored value, never bypassed).
- Scoreboard: one busy bit per register; bit 0 is constantly 0.
  - Edge with ISSUE_EN = 1 and ISSUE_AD != 0: busy[ISSUE_AD] <= 1.
  - Edge with WE3 = 1 and AD3 != 0: busy[AD3] <= 0.
  - Same edge, same address, issue and write together: busy ends at 1 (the newer producer wins).
  - Same edge, different addresses: both updates apply.
- BUSYx:
  - BUSYx = busy[ADx], except forced 0 when ADx == 0.
  - Also forced 0 when BYPASS = 1 and WE3 = 1 and AD3 == ADx, because the bypassed data is valid that cycle.
- Data width: no sign extension or arithmetic. RD1, RD2 and a0 are declared signed only for the ALU's benefit.
- Latency: write-to-array is 1 edge; read with bypass is 0 cycles; issue-to-BUSY is 1 edge.

Test Plan:
1. Reset clear: pulse rst, then 32 cycles with WE3 = 1, AD3 = 5, WD3 = 0xDEADBEEF.
   - ready must rise exactly 32 cycles after rst falls.
   - AD1 = 5 must then read 0, because writes are ignored during INIT.
2. Register 0 and a0:
   - WE3 AD3 = 0, WD3 = 0x1234 -> RD1 with AD1 = 0 reads 0.
   - WE3 AD3 = 10, WD3 = 0xFFFFFFFF -> a0 = -1 on the next cycle.
3. Bypass: same cycle WE3 AD3 = 7, WD3 = 0xA5A5A5A5, AD1 = AD2 = 7.
   - BYPASS = 1: RD1 = RD2 = 0xA5A5A5A5 in that cycle.
   - BYPASS = 0: old value in that cycle, new value next cycle.
4. Scoreboard: ISSUE_EN with ISSUE_AD = 3, then AD1 = 3.
   - BUSY1 = 1 for the following cycles.
   - WE3 AD3 = 3 -> BUSY1 = 0 in that cycle (BYPASS = 1) and after the edge.
   - ISSUE_AD = 0 never sets BUSY.
5. Simultaneous issue and write on register 4, with busy[4] = 1 beforehand -> BUSY1 (AD1 = 4) = 1 after the edge.
6. Reset mid-run:
   - Busy bits set, rst asserted asynchronously between edges -> ready, BUSY1, BUSY2, RD1, RD2 and a0 go to 0 immediately.
   - The full 32-cycle clear then repeats.
